// File: rtl/count_chk_pkg.sv
// Shared definitions for the mod-count checker.
//   chk_state_e : checker FSM state encoding
//   DEF_CNT_W   : default width of the count bus
//   DEF_MOD     : default modulus of the upstream counter
package count_chk_pkg;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_SYNCING  = 2'd1,
    ST_LOCKED   = 2'd2
  } chk_state_e;

  localparam int DEF_CNT_W = 4;
  localparam int DEF_MOD   = 9;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, reset : clock, synchronous active-high reset
//   clr        : clear to zero (an inc on the same cycle leaves q=1)
//   inc        : increment, holds at all-ones
//   q          : count value
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= inc ? W'(1) : '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/mod_count_checker.sv
// Consumer of a mod-MOD count bus: locks onto the 0..MOD-1 ramp, flags
// out-of-sequence / out-of-range samples while locked, and emits a
// one-cycle wrap pulse per completed cycle.
//   clk, reset  : clock, synchronous active-high reset
//   cnt_in      : count sample, qualified by cnt_valid
//   clr_err     : clear err / err_count / last_bad
//   locked      : checker is locked onto the ramp
//   exp_val     : next expected value
//   wrap_pulse  : one-cycle pulse on a locked (MOD-1)->0 step
//   wrap_count  : saturating count of wrap pulses
//   err         : sticky error flag
//   err_count   : saturating count of errors
//   last_bad    : most recent bad sample
//
// state       | meaning
// ------------+-----------------------------------------------
// ST_UNLOCKED | waiting for any in-range sample to anchor on
// ST_SYNCING  | counting consecutive correct steps (good)
// ST_LOCKED   | tracking the ramp, errors are counted
module mod_count_checker
  import count_chk_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int MOD        = DEF_MOD,
  parameter int SYNC_LEN   = 2,
  parameter int WRAP_W     = 16,
  parameter int ERR_W      = 8,
  parameter bit ALLOW_HOLD = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CNT_W-1:0]  cnt_in,
  input  logic              cnt_valid,
  input  logic              clr_err,
  output logic              locked,
  output logic [CNT_W-1:0]  exp_val,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              err,
  output logic [ERR_W-1:0]  err_count,
  output logic [CNT_W-1:0]  last_bad
);

  localparam int GOOD_W = $clog2(SYNC_LEN + 1);
  localparam logic [CNT_W-1:0]  MOD_M1   = CNT_W'(MOD - 1);
  localparam logic [GOOD_W-1:0] SYNC_TGT = GOOD_W'(SYNC_LEN);

  function automatic logic [CNT_W-1:0] nxt(input logic [CNT_W-1:0] x);
    return (x == MOD_M1) ? '0 : x + 1'b1;
  endfunction

  chk_state_e        state, state_nxt;
  logic [CNT_W-1:0]  prev, prev_nxt;
  logic [GOOD_W-1:0] good, good_nxt, good_inc;
  logic              prev_ld;
  logic              err_det;
  logic              wrap_det;
  logic              in_range;
  logic              match;

  assign in_range = (cnt_in <= MOD_M1);
  assign match    = (cnt_in == nxt(prev));
  assign good_inc = good + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_UNLOCKED;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    prev_nxt  = prev;
    good_nxt  = good;
    prev_ld   = 1'b0;
    err_det   = 1'b0;
    wrap_det  = 1'b0;
    if (cnt_valid) begin
      case (state)
        ST_UNLOCKED: begin
          if (in_range) begin
            prev_nxt  = cnt_in;
            prev_ld   = 1'b1;
            good_nxt  = '0;
            state_nxt = ST_SYNCING;
          end
        end
        ST_SYNCING: begin
          if (match) begin
            prev_nxt = cnt_in;
            prev_ld  = 1'b1;
            if (good_inc == SYNC_TGT) begin
              good_nxt  = '0;
              state_nxt = ST_LOCKED;
            end else begin
              good_nxt = good_inc;
            end
          end else if (in_range) begin
            prev_nxt = cnt_in;
            prev_ld  = 1'b1;
            good_nxt = '0;
          end else begin
            good_nxt  = '0;
            state_nxt = ST_UNLOCKED;
          end
        end
        ST_LOCKED: begin
          if (match) begin
            prev_nxt = cnt_in;
            prev_ld  = 1'b1;
            // a match from MOD-1 can only be 0, so this is the wrap step
            wrap_det = (prev == MOD_M1);
          end else if (ALLOW_HOLD && (cnt_in == prev)) begin
            prev_ld = 1'b0;
          end else begin
            err_det  = 1'b1;
            good_nxt = '0;
            if (in_range) begin
              prev_nxt  = cnt_in;
              prev_ld   = 1'b1;
              state_nxt = ST_SYNCING;
            end else begin
              state_nxt = ST_UNLOCKED;
            end
          end
        end
        default: begin
          good_nxt  = '0;
          state_nxt = ST_UNLOCKED;
        end
      endcase
    end
  end

  // exp_val is its own register so it reads 0 out of reset rather than nxt(0)
  always_ff @(posedge clk) begin
    if (reset) begin
      prev       <= '0;
      good       <= '0;
      exp_val    <= '0;
      wrap_pulse <= 1'b0;
      err        <= 1'b0;
      last_bad   <= '0;
    end else begin
      prev       <= prev_nxt;
      good       <= good_nxt;
      wrap_pulse <= wrap_det;
      if (prev_ld) begin
        exp_val <= nxt(prev_nxt);
      end
      if (err_det) begin
        err      <= 1'b1;
        last_bad <= cnt_in;
      end else if (clr_err) begin
        err      <= 1'b0;
        last_bad <= '0;
      end
    end
  end

  assign locked = (state == ST_LOCKED);

  sat_counter #(.W(WRAP_W)) u_wrap_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (wrap_det),
    .q     (wrap_count)
  );

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_err),
    .inc   (err_det),
    .q     (err_count)
  );

endmodule

// File: tb/tb_mod_count_checker.sv
module tb_mod_count_checker;

  localparam int MODV  = 9;
  localparam int SYNCL = 2;
  localparam int ERRMX = 255;
  localparam int WRPMX = 65535;

  logic        clk;
  logic        reset;
  logic [3:0]  cnt_in;
  logic        cnt_valid;
  logic        clr_err;
  logic        locked;
  logic [3:0]  exp_val;
  logic        wrap_pulse;
  logic [15:0] wrap_count;
  logic        err;
  logic [7:0]  err_count;
  logic [3:0]  last_bad;

  mod_count_checker dut (
    .clk        (clk),
    .reset      (reset),
    .cnt_in     (cnt_in),
    .cnt_valid  (cnt_valid),
    .clr_err    (clr_err),
    .locked     (locked),
    .exp_val    (exp_val),
    .wrap_pulse (wrap_pulse),
    .wrap_count (wrap_count),
    .err        (err),
    .err_count  (err_count),
    .last_bad   (last_bad)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference model: the checker is "anchored" on a previous value and
  // counts a streak of correct steps; it is locked once the streak
  // reaches SYNCL. Errors only count while locked.
  bit m_anch;
  int m_streak, m_prev, m_exp, m_wp, m_wc, m_err, m_ec, m_lb;

  function automatic bit m_locked();
    return m_anch && (m_streak >= SYNCL);
  endfunction

  task automatic model_reset();
    m_anch = 0; m_streak = 0; m_prev = 0; m_exp = 0;
    m_wp = 0; m_wc = 0; m_err = 0; m_ec = 0; m_lb = 0;
  endtask

  task automatic model_step(input bit v, input int x, input bit c);
    bit was_locked, bad;
    was_locked = m_locked();
    bad = 0;
    m_wp = 0;
    if (v) begin
      if (m_anch && x == (m_prev + 1) % MODV) begin
        if (was_locked && m_prev == MODV - 1) begin
          m_wp = 1;
          if (m_wc < WRPMX) m_wc++;
        end
        m_streak++;
        m_prev = x;
        m_exp = (x + 1) % MODV;
      end else begin
        bad = was_locked;
        m_streak = 0;
        if (x < MODV) begin
          m_anch = 1;
          m_prev = x;
          m_exp = (x + 1) % MODV;
        end else begin
          m_anch = 0;
        end
      end
    end
    if (bad) begin
      m_err = 1;
      m_lb = x;
      m_ec = c ? 1 : ((m_ec < ERRMX) ? m_ec + 1 : ERRMX);
    end else if (c) begin
      m_err = 0; m_ec = 0; m_lb = 0;
    end
  endtask

  task automatic compare_all();
    chk("locked",     locked,     m_locked());
    chk("exp_val",    exp_val,    m_exp);
    chk("wrap_pulse", wrap_pulse, m_wp);
    chk("wrap_count", wrap_count, m_wc);
    chk("err",        err,        m_err);
    chk("err_count",  err_count,  m_ec);
    chk("last_bad",   last_bad,   m_lb);
  endtask

  task automatic drive_cycle(input bit v, input int x, input bit c);
    cnt_valid = v;
    cnt_in    = x[3:0];
    clr_err   = c;
    @(posedge clk);
    #1;
    model_step(v, x, c);
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1; cnt_valid = 1'b1; cnt_in = 4'd5; clr_err = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0; cnt_valid = 1'b0; clr_err = 1'b0;
    model_reset();
    compare_all();
  endtask

  typedef struct {
    bit v; int x; bit c;
    bit lk; bit er; int ec; int lb; bit wp; int wc;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input bit v, input int x, input bit c, input bit lk,
                         input bit er, input int ec, input int lb,
                         input bit wp, input int wc);
    vec_t t;
    t.v = v; t.x = x; t.c = c; t.lk = lk; t.er = er;
    t.ec = ec; t.lb = lb; t.wp = wp; t.wc = wc;
    vecs.push_back(t);
  endtask

  initial begin
    int wp_seen, src, x, last_x;
    bit v, c;
    reset = 1'b1; cnt_valid = 1'b0; cnt_in = '0; clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    compare_all();

    // free-running ramp: lock on 3rd sample, three wraps
    do_reset();
    wp_seen = 0;
    for (int i = 0; i < 28; i++) begin
      drive_cycle(1, i % MODV, 0);
      wp_seen += wrap_pulse;
      if (i == 1) chk("ramp_not_locked_2nd", locked, 0);
      if (i == 2) chk("ramp_locked_3rd", locked, 1);
    end
    chk("ramp_wrap_pulses", wp_seen, 3);
    chk("ramp_wrap_count", wrap_count, 3);

    // valid low for 10 cycles while locked, then resume
    for (int i = 0; i < 10; i++) begin
      drive_cycle(0, $urandom_range(0, 15), 0);
      chk("pause_locked", locked, 1);
      chk("pause_exp", exp_val, 1);
      chk("pause_wp", wrap_pulse, 0);
    end
    for (int i = 1; i <= 9; i++) drive_cycle(1, i % MODV, 0);
    chk("resume_err", err, 0);
    chk("resume_wrap_count", wrap_count, 4);

    // directed vector table
    do_reset();
    add_vec(1, 0,  0, 0, 0, 0, 0,  0, 0);
    add_vec(1, 1,  0, 0, 0, 0, 0,  0, 0);
    add_vec(1, 2,  0, 1, 0, 0, 0,  0, 0);
    add_vec(1, 3,  0, 1, 0, 0, 0,  0, 0);
    add_vec(1, 5,  0, 0, 1, 1, 5,  0, 0);
    add_vec(1, 6,  0, 0, 1, 1, 5,  0, 0);
    add_vec(1, 7,  0, 1, 1, 1, 5,  0, 0);
    add_vec(1, 8,  0, 1, 1, 1, 5,  0, 0);
    add_vec(1, 0,  0, 1, 1, 1, 5,  1, 1);
    add_vec(1, 12, 0, 0, 1, 2, 12, 0, 1);
    add_vec(1, 0,  0, 0, 1, 2, 12, 0, 1);
    add_vec(1, 1,  0, 0, 1, 2, 12, 0, 1);
    add_vec(1, 2,  0, 1, 1, 2, 12, 0, 1);
    add_vec(1, 3,  1, 1, 0, 0, 0,  0, 1);
    add_vec(1, 3,  1, 0, 1, 1, 3,  0, 1);
    add_vec(1, 4,  0, 0, 1, 1, 3,  0, 1);
    add_vec(0, 9,  0, 0, 1, 1, 3,  0, 1);
    add_vec(1, 5,  0, 1, 1, 1, 3,  0, 1);
    foreach (vecs[i]) begin
      drive_cycle(vecs[i].v, vecs[i].x, vecs[i].c);
      chk($sformatf("tbl%0d_locked", i),    locked,     vecs[i].lk);
      chk($sformatf("tbl%0d_err", i),       err,        vecs[i].er);
      chk($sformatf("tbl%0d_err_count", i), err_count,  vecs[i].ec);
      chk($sformatf("tbl%0d_last_bad", i),  last_bad,   vecs[i].lb);
      chk($sformatf("tbl%0d_wrap_pulse", i), wrap_pulse, vecs[i].wp);
      chk($sformatf("tbl%0d_wrap_count", i), wrap_count, vecs[i].wc);
    end

    // 300 errors: err_count saturates
    do_reset();
    for (int i = 0; i < 3; i++) drive_cycle(1, i, 0);
    for (int n = 0; n < 300; n++) begin
      drive_cycle(1, 15, 0);
      for (int i = 0; i < 3; i++) drive_cycle(1, i, 0);
    end
    chk("sat_err_count", err_count, 255);
    chk("sat_last_bad", last_bad, 15);

    // reset mid-ramp
    drive_cycle(1, 3, 0);
    drive_cycle(1, 4, 0);
    do_reset();
    chk("midrst_locked", locked, 0);
    chk("midrst_err_count", err_count, 0);
    chk("midrst_exp_val", exp_val, 0);

    // randomized traffic against the model
    src = 0; last_x = 0;
    for (int n = 0; n < 4000; n++) begin
      int r;
      v = ($urandom_range(0, 99) < 85);
      c = ($urandom_range(0, 99) < 4);
      r = $urandom_range(0, 99);
      if (r < 85) begin
        x = src;
        if (v) src = (src + 1) % MODV;
      end else if (r < 93) begin
        x = $urandom_range(0, 15);
        if (v && x < MODV) src = (x + 1) % MODV;
      end else begin
        x = last_x;
      end
      if (v) last_x = x;
      drive_cycle(v, x, c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
